// File: rtl/max_product_seq.sv
// ---------------------------------------------------------------------------
// max_product_seq
//
// Time-multiplexed max-log (max-product) soft-output decoder back end. A block
// of 1..MAX_SYMBOLS symbols of branch metrics and forward (alpha) metrics is
// streamed in and buffered. The backward (beta) recursion then runs from the
// last symbol to the first. Each step produces one registered set of per-bit
// LLRs, so LLRs leave last-symbol-first with ready/valid backpressure.
//
// Ports
//   clk                 clock
//   rst                 asynchronous reset, active high
//   trellis_next_state  next_state[s][u], entry (s*INPUT_SYMBOLS+u), SW bits each
//   trellis_out_sym     out_sym[s][u] branch label, same ordering, OW bits each
//   in_valid/in_ready   input handshake (ready only while loading)
//   in_bm               branch metric per output label, label i at [i*BITS +: BITS]
//   in_alpha            forward metric per state, state s at [s*BITS +: BITS]
//   in_last             current input is the final symbol of the block
//   out_valid/out_ready output handshake
//   out_llr             LLR per input bit, bit b at [b*BITS +: BITS] (b=0 is LSB of u)
//   out_index           symbol index of out_llr
//   out_last            out_index == 0, block complete
//   busy                decoding or draining the final LLR set
//   err_len             sticky: a block filled the buffer without in_last
//
// All metric arithmetic is signed and saturating. The most negative value
// doubles as "-infinity" (unreachable state / path).
// ---------------------------------------------------------------------------
module max_product_seq #(
    parameter int BITS            = 16,
    parameter int BITS_PER_SYMBOL = 2,
    parameter int STATES          = 4,
    parameter int OUTPUT_SYMBOLS  = 4,
    parameter int MAX_SYMBOLS     = 64,
    parameter int TERMINATED      = 1,
    localparam int INPUT_SYMBOLS  = 2 ** BITS_PER_SYMBOL,
    localparam int SW             = (STATES > 1) ? $clog2(STATES) : 1,
    localparam int OW             = (OUTPUT_SYMBOLS > 1) ? $clog2(OUTPUT_SYMBOLS) : 1,
    localparam int IW             = (MAX_SYMBOLS > 1) ? $clog2(MAX_SYMBOLS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [STATES*INPUT_SYMBOLS*SW-1:0]   trellis_next_state,
    input  logic [STATES*INPUT_SYMBOLS*OW-1:0]   trellis_out_sym,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [BITS*OUTPUT_SYMBOLS-1:0]       in_bm,
    input  logic [BITS*STATES-1:0]               in_alpha,
    input  logic                                 in_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [BITS*BITS_PER_SYMBOL-1:0]      out_llr,
    output logic [IW-1:0]                        out_index,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 err_len
);

    // -----------------------------------------------------------------------
    // state    | meaning
    // ST_LOAD  | accepting metrics into the buffer, in_ready high
    // ST_RUN   | backward recursion, one LLR set per accepted output slot
    // ST_DRAIN | index 0 issued, waiting for its output handshake
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef logic signed [BITS-1:0] metric_t;
    // Two guard bits hold the exact sum of three metrics before saturation.
    typedef logic signed [BITS+1:0] wide_t;

    localparam metric_t MAX_M = {1'b0, {(BITS-1){1'b1}}};
    localparam metric_t MIN_M = {1'b1, {(BITS-1){1'b0}}};
    localparam wide_t   MAX_W = {3'b000, {(BITS-1){1'b1}}};
    localparam wide_t   MIN_W = {3'b111, {(BITS-1){1'b0}}};

    function automatic wide_t ext(input metric_t a);
        return {{2{a[BITS-1]}}, a};
    endfunction

    function automatic metric_t sat(input wide_t x);
        if (x > MAX_W) return MAX_M;
        if (x < MIN_W) return MIN_M;
        return x[BITS-1:0];
    endfunction

    state_t         state_q;
    state_t         state_d;

    metric_t        bm_buf    [MAX_SYMBOLS][OUTPUT_SYMBOLS];
    metric_t        alpha_buf [MAX_SYMBOLS][STATES];

    metric_t        beta_q    [STATES];
    metric_t        beta_nxt  [STATES];
    metric_t        llr_nxt   [BITS_PER_SYMBOL];
    metric_t        llr_q     [BITS_PER_SYMBOL];

    logic [IW-1:0]  count_q;
    logic [IW-1:0]  idx_q;
    logic [IW-1:0]  out_index_q;
    logic           out_valid_q;
    logic           out_last_q;
    logic           err_len_q;

    logic           in_fire;
    logic           last_xfer;
    logic           out_fire;
    logic           advance;

    // -----------------------------------------------------------------------
    // Handshake qualifiers
    // -----------------------------------------------------------------------
    assign in_fire   = in_valid && in_ready;
    // A full buffer closes the block even without in_last.
    assign last_xfer = in_fire && (in_last || (count_q == IW'(MAX_SYMBOLS - 1)));
    assign out_fire  = out_valid_q && out_ready;
    // Step the recursion only when the output register is free or being
    // emptied this cycle; this keeps out_* frozen under backpressure.
    assign advance   = (state_q == ST_RUN) && (!out_valid_q || out_ready);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (last_xfer) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (advance && (idx_q == '0)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_fire) state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            ST_LOAD:  in_ready = 1'b1;
            ST_RUN:   busy     = 1'b1;
            ST_DRAIN: busy     = 1'b1;
            default:  in_ready = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Metric buffer, deliberately without reset
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int o = 0; o < OUTPUT_SYMBOLS; o++) begin
                bm_buf[count_q][o] <= in_bm[o*BITS +: BITS];
            end
            for (int s = 0; s < STATES; s++) begin
                alpha_buf[count_q][s] <= in_alpha[s*BITS +: BITS];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Shared symbol datapath: path metrics, per-bit LLRs and the next beta
    // -----------------------------------------------------------------------
    always_comb begin
        metric_t       best1 [BITS_PER_SYMBOL];
        metric_t       best0 [BITS_PER_SYMBOL];
        metric_t       bnew  [STATES];
        metric_t       bm_v;
        metric_t       beta_v;
        metric_t       path_m;
        metric_t       branch_g;
        logic [SW-1:0] ns;
        logic [OW-1:0] lab;

        for (int b = 0; b < BITS_PER_SYMBOL; b++) begin
            best1[b] = MIN_M;
            best0[b] = MIN_M;
        end
        for (int s = 0; s < STATES; s++) begin
            bnew[s] = MIN_M;
        end
        bm_v     = '0;
        beta_v   = '0;
        path_m   = '0;
        branch_g = '0;
        ns       = '0;
        lab      = '0;

        for (int s = 0; s < STATES; s++) begin
            for (int u = 0; u < INPUT_SYMBOLS; u++) begin
                ns       = trellis_next_state[(s*INPUT_SYMBOLS+u)*SW +: SW];
                lab      = trellis_out_sym[(s*INPUT_SYMBOLS+u)*OW +: OW];
                bm_v     = bm_buf[idx_q][lab];
                beta_v   = beta_q[ns];
                branch_g = sat(ext(bm_v) + ext(beta_v));
                path_m   = sat(ext(alpha_buf[idx_q][s]) + ext(bm_v) + ext(beta_v));
                if (branch_g > bnew[s]) bnew[s] = branch_g;
                for (int b = 0; b < BITS_PER_SYMBOL; b++) begin
                    if (((u >> b) & 1) == 1) begin
                        if (path_m > best1[b]) best1[b] = path_m;
                    end else begin
                        if (path_m > best0[b]) best0[b] = path_m;
                    end
                end
            end
        end

        for (int b = 0; b < BITS_PER_SYMBOL; b++) begin
            llr_nxt[b] = sat(ext(best1[b]) - ext(best0[b]));
        end
        // Normalise against state 0 so beta stays bounded over long blocks.
        for (int s = 0; s < STATES; s++) begin
            beta_nxt[s] = sat(ext(bnew[s]) - ext(bnew[0]));
        end
    end

    // -----------------------------------------------------------------------
    // Counters, beta register and output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            idx_q       <= '0;
            out_index_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_len_q   <= 1'b0;
            for (int s = 0; s < STATES; s++) begin
                beta_q[s] <= '0;
            end
            for (int b = 0; b < BITS_PER_SYMBOL; b++) begin
                llr_q[b] <= '0;
            end
        end else begin
            if (in_fire) begin
                count_q <= last_xfer ? '0 : count_q + 1'b1;
            end
            if (last_xfer) begin
                idx_q <= count_q;
                for (int s = 0; s < STATES; s++) begin
                    beta_q[s] <= ((TERMINATED != 0) && (s != 0)) ? MIN_M : '0;
                end
                if (!in_last) err_len_q <= 1'b1;
            end
            if (advance) begin
                out_valid_q <= 1'b1;
                out_index_q <= idx_q;
                out_last_q  <= (idx_q == '0);
                for (int b = 0; b < BITS_PER_SYMBOL; b++) begin
                    llr_q[b] <= llr_nxt[b];
                end
                for (int s = 0; s < STATES; s++) begin
                    beta_q[s] <= beta_nxt[s];
                end
                if (idx_q != '0) idx_q <= idx_q - 1'b1;
            end else if ((state_q == ST_DRAIN) && out_fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        out_llr = '0;
        for (int b = 0; b < BITS_PER_SYMBOL; b++) begin
            out_llr[b*BITS +: BITS] = llr_q[b];
        end
    end

    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign err_len   = err_len_q;

endmodule

// File: tb/tb_max_product_seq.sv
// Bench for max_product_seq: two instances (unterminated / terminated tail)
// driven by the same input stream, checked against a behavioural max-log model.
module tb_max_product_seq;
    localparam int BITS = 16;
    localparam int ST   = 2;
    localparam int OS   = 4;
    localparam int MAXS = 4;
    localparam int MINV = -32768;
    localparam int MAXV = 32767;

    typedef struct {
        int idx;
        int llr;
        int last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_last, out_ready;
    logic [BITS*OS-1:0] in_bm;
    logic [BITS*ST-1:0] in_alpha;
    logic [ST*2-1:0]    tr_ns;
    logic [ST*2*2-1:0]  tr_os;

    logic            in_ready0, out_valid0, out_last0, busy0, err0;
    logic            in_ready1, out_valid1, out_last1, busy1, err1;
    logic [BITS-1:0] out_llr0, out_llr1;
    logic [1:0]      out_index0, out_index1;

    int   tests = 0;
    int   fails = 0;
    int   exp_err = 0;
    int   blk_bm [MAXS][OS];
    int   blk_al [MAXS][ST];
    exp_t q0[$];
    exp_t q1[$];
    logic hold [2];
    int   snap_llr [2];
    int   snap_ix [2];

    always #5 clk = ~clk;

    max_product_seq #(.BITS(BITS), .BITS_PER_SYMBOL(1), .STATES(ST), .OUTPUT_SYMBOLS(OS),
                      .MAX_SYMBOLS(MAXS), .TERMINATED(0)) u_dut0 (
        .clk(clk), .rst(rst), .trellis_next_state(tr_ns), .trellis_out_sym(tr_os),
        .in_valid(in_valid), .in_ready(in_ready0), .in_bm(in_bm), .in_alpha(in_alpha),
        .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready), .out_llr(out_llr0),
        .out_index(out_index0), .out_last(out_last0), .busy(busy0), .err_len(err0));

    max_product_seq #(.BITS(BITS), .BITS_PER_SYMBOL(1), .STATES(ST), .OUTPUT_SYMBOLS(OS),
                      .MAX_SYMBOLS(MAXS), .TERMINATED(1)) u_dut1 (
        .clk(clk), .rst(rst), .trellis_next_state(tr_ns), .trellis_out_sym(tr_os),
        .in_valid(in_valid), .in_ready(in_ready1), .in_bm(in_bm), .in_alpha(in_alpha),
        .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready), .out_llr(out_llr1),
        .out_index(out_index1), .out_last(out_last1), .busy(busy1), .err_len(err1));

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int sat(input int x);
        if (x > MAXV) return MAXV;
        if (x < MINV) return MINV;
        return x;
    endfunction

    // Test trellis: input bit u drives the next state; label = {u, u^s}.
    function automatic int label(input int s, input int u);
        return 2 * u + (u ^ s);
    endfunction

    // Max-log backward pass over the buffered block, both tail variants.
    function automatic void model(input int k);
        for (int t = 0; t < 2; t++) begin
            int beta [ST];
            for (int s = 0; s < ST; s++) beta[s] = (t == 1 && s != 0) ? MINV : 0;
            for (int i = k - 1; i >= 0; i--) begin
                int best [2];
                int nb [ST];
                int l;
                best[0] = MINV;
                best[1] = MINV;
                for (int s = 0; s < ST; s++) begin
                    nb[s] = MINV;
                    for (int u = 0; u < 2; u++) begin
                        int m;
                        int g;
                        m = sat(blk_al[i][s] + blk_bm[i][label(s, u)] + beta[u]);
                        g = sat(blk_bm[i][label(s, u)] + beta[u]);
                        if (m > best[u]) best[u] = m;
                        if (g > nb[s]) nb[s] = g;
                    end
                end
                l = sat(best[1] - best[0]);
                for (int s = 0; s < ST; s++) beta[s] = sat(nb[s] - nb[0]);
                if (t == 0) q0.push_back('{i, l, int'(i == 0)});
                else        q1.push_back('{i, l, int'(i == 0)});
            end
        end
    endfunction

    function automatic int rnd_metric();
        case ($urandom_range(0, 4))
            0:       return MINV;
            1:       return MAXV;
            2:       return int'($urandom_range(0, 65535)) - 32768;
            default: return int'($urandom_range(0, 400)) - 200;
        endcase
    endfunction

    task automatic rand_block(input int k);
        for (int i = 0; i < k; i++) begin
            for (int o = 0; o < OS; o++) blk_bm[i][o] = rnd_metric();
            for (int s = 0; s < ST; s++) blk_al[i][s] = rnd_metric();
        end
    endtask

    task automatic check_out(input int t, input logic v, input logic [BITS-1:0] llr,
                             input logic [1:0] ix, input logic lst);
        exp_t e;
        int   sl;
        int   n;
        sl = int'($signed(llr));
        if (v && hold[t]) begin
            chk($sformatf("hold_llr%0d", t), sl, snap_llr[t]);
            chk($sformatf("hold_idx%0d", t), int'(ix), snap_ix[t]);
        end
        if (v && out_ready) begin
            n = (t == 0) ? q0.size() : q1.size();
            chk($sformatf("pending_set%0d", t), int'(n > 0), 1);
            if (n > 0) begin
                if (t == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("out_index%0d", t), int'(ix), e.idx);
                chk($sformatf("out_llr%0d_idx%0d", t, e.idx), sl, e.llr);
                chk($sformatf("out_last%0d", t), int'(lst), e.last);
            end
        end
        hold[t]     = v && !out_ready;
        snap_llr[t] = sl;
        snap_ix[t]  = int'(ix);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold[0] = 1'b0;
            hold[1] = 1'b0;
        end else begin
            check_out(0, out_valid0, out_llr0, out_index0, out_last0);
            check_out(1, out_valid1, out_llr1, out_index1, out_last1);
        end
    end

    task automatic send_block(input int k, input bit with_last, input bit gaps);
        model(k);
        if (!with_last) exp_err = 1;
        for (int i = 0; i < k; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            chk("in_ready_load", int'(in_ready0 & in_ready1), 1);
            in_valid = 1'b1;
            in_last  = with_last && (i == k - 1);
            for (int o = 0; o < OS; o++) in_bm[o*BITS +: BITS] = BITS'(blk_bm[i][o]);
            for (int s = 0; s < ST; s++) in_alpha[s*BITS +: BITS] = BITS'(blk_al[i][s]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // mode 0: out_ready held high; mode 1: random backpressure and junk inputs
    task automatic wait_drain(input int mode);
        int cyc;
        cyc = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && in_ready0 && in_ready1)) begin
            if (cyc >= 200) begin
                chk("drain_timeout_cycles", cyc, 0);
                break;
            end
            out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (mode == 1 && !in_ready0) begin
                in_valid = 1'($urandom_range(0, 1));
                in_last  = 1'($urandom_range(0, 1));
                in_bm    = {$urandom, $urandom};
                in_alpha = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        chk("err_len0", int'(err0), exp_err);
        chk("err_len1", int'(err1), exp_err);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        in_bm     = '0;
        in_alpha  = '0;
        for (int s = 0; s < ST; s++) begin
            for (int u = 0; u < 2; u++) begin
                tr_ns[s*2+u]         = 1'(u);
                tr_os[(s*2+u)*2 +: 2] = 2'(label(s, u));
            end
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready0 & in_ready1), 1);
        chk("rst_out_valid", int'(out_valid0 | out_valid1), 0);
        chk("rst_busy", int'(busy0 | busy1), 0);
        chk("rst_err", int'(err0 | err1), 0);
        chk("rst_out_llr", int'(out_llr0 | out_llr1), 0);
        chk("rst_out_index_last", int'({out_index0, out_last0}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // K=1 terminated: state 1 unreachable at the end, so u=1 is -inf.
        blk_al[0] = '{0, MINV};
        blk_bm[0] = '{0, 0, 0, 0};
        send_block(1, 1'b1, 1'b0);
        chk("pin_term_k1", q1[0].llr, MINV);
        @(posedge clk); #1;
        chk("k1_term_valid", int'(out_valid1), 1);
        chk("k1_term_llr", int'($signed(out_llr1)), -32768);
        chk("k1_term_index", int'(out_index1), 0);
        chk("k1_term_last", int'(out_last1), 1);
        wait_drain(0);

        // K=1 unterminated: only path u=1 from state 0 (label 3) carries +5.
        blk_al[0] = '{0, MINV};
        blk_bm[0] = '{0, 0, 0, 5};
        send_block(1, 1'b1, 1'b0);
        chk("pin_unterm_k1", q0[0].llr, 5);
        chk("k1_latency_early", int'(out_valid0), 0);
        @(posedge clk); #1;
        chk("k1_latency_valid", int'(out_valid0), 1);
        chk("k1_unterm_llr", int'($signed(out_llr0)), 5);
        wait_drain(0);

        // Mixed metrics: hand-derived 100 (unterminated), MIN+100 (terminated).
        blk_al[0] = '{0, 0};
        blk_bm[0] = '{100, -100, 200, 50};
        model(1);
        chk("pin_mix_unterm", q0[0].llr, 100);
        chk("pin_mix_term", q1[0].llr, -32668);
        q0.delete();
        q1.delete();
        send_block(1, 1'b1, 1'b0);
        wait_drain(0);

        // K=3 at full throughput: indices 2,1,0 on consecutive cycles.
        rand_block(3);
        send_block(3, 1'b1, 1'b0);
        chk("k3_busy_run", int'(busy0 & busy1), 1);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            chk("k3_valid", int'(out_valid0), 1);
            chk("k3_index_seq", int'(out_index0), 2 - j);
            chk("k3_busy", int'(busy0), 1);
        end
        @(posedge clk); #1;
        chk("k3_busy_done", int'(busy0), 0);
        chk("k3_in_ready_back", int'(in_ready0), 1);
        chk("k3_out_valid_done", int'(out_valid0), 0);
        wait_drain(0);

        // K=3 with 4 stalled cycles on index 1.
        rand_block(3);
        send_block(3, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("stall_index", int'(out_index0), 1);
        out_ready = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("stall_held_index", int'(out_index0), 1);
            chk("stall_held_valid", int'(out_valid0 & out_valid1), 1);
        end
        out_ready = 1'b1;
        wait_drain(0);

        // Buffer overflow: 4 symbols without in_last, then a normal block.
        rand_block(4);
        send_block(4, 1'b0, 1'b0);
        wait_drain(1);
        rand_block(2);
        send_block(2, 1'b1, 1'b1);
        wait_drain(1);

        // Asynchronous reset in the middle of a block.
        rand_block(4);
        send_block(4, 1'b1, 1'b0);
        out_ready = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid0 | out_valid1), 0);
        chk("midrst_busy", int'(busy0 | busy1), 0);
        chk("midrst_in_ready", int'(in_ready0 & in_ready1), 1);
        q0.delete();
        q1.delete();
        exp_err = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        rand_block(3);
        send_block(3, 1'b1, 1'b1);
        wait_drain(1);

        // Randomized blocks with gaps, backpressure and junk inputs while busy.
        for (int n = 0; n < 30; n++) begin
            int  k;
            bit  with_last;
            k = $urandom_range(1, MAXS);
            with_last = (k < MAXS) ? 1'b1 : 1'($urandom_range(0, 1));
            rand_block(k);
            send_block(k, with_last, 1'b1);
            wait_drain(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
